xc_malu_mul_seq: RTL and testbench
==================================

Name: xc_malu_mul_seq

Overview:
Self-contained, parametrised iterative shift-add multiplier for the MALU. It owns its accumulator, operand shift register, step counter and handshakes, and retires STEP multiplier bits per cycle. It supports mul, mulh, mulhu, mulhsu, clmul and clmulh at any XLEN. Its functional unit sits beside the packed adder path, but it does not share that adder: all additions are internal.

Parameters:
XLEN, 32, operand and result width; power of two, 8..64.
STEP, 1, multiplier bits consumed per cycle; power of two, 1..8, must divide XLEN.

Ports:
g_clk  input  1  clock; all state updates on the rising edge.
g_resetn  input  1  reset; synchronous, active-low.
flush  input  1  abort any operation in progress; no response is produced.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
rs1  input  XLEN  multiplicand.
rs2  input  XLEN  multiplier.
lhs_sign  input  1  treat rs1 as signed.
rhs_sign  input  1  treat rs2 as signed.
carryless  input  1  GF(2) product: XOR accumulate; sign inputs are ignored.
high  input  1  return upper XLEN bits of the product; otherwise lower.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer takes the result.
result  output  XLEN  product half selected by the latched high flag.

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset outputs: req_ready=1, rsp_valid=0, result=0. Accumulator, counter and latched flags are cleared.
- req_ready = (state==IDLE). rsp_valid = (state==DONE). result is driven from registers only and is zero outside DONE.
- IDLE: on req_valid && req_ready:
  - latch rs1, rs2 and all four mode bits;
  - clear the 2*XLEN accumulator and counter;
  - move to RUN.
- RUN, each cycle:
  - form the partial product of the latched multiplicand (sign-extended by one bit when lhs_sign && !carryless) with the low STEP bits of the multiplier;
  - add it to acc[2*XLEN-1:XLEN] (XOR when carryless);
  - shift the accumulator right by STEP, inserting the sum's carry/sign bits at the top;
  - shift the multiplier right by STEP;
  - count += 1.
- Signed multiplier: when rhs_sign && !carryless, bit XLEN-1 of rs2 carries weight -2^(XLEN-1). In the final step its term is subtracted rather than added.
- RUN -> DONE after exactly XLEN/STEP RUN cycles. rsp_valid rises on the edge ending the last RUN cycle, so it is first high XLEN/STEP cycles after the accept edge.
- Product semantics:
  - acc holds the exact 2*XLEN-bit two's-complement product (or carryless product) of the operands under the latched signedness;
  - result = high ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0].
- DONE: result and rsp_valid are held stable until rsp_ready. On rsp_valid && rsp_ready -> IDLE.
- Back-to-back issue: req_ready is never high in the same cycle as rsp_valid. The minimum issue interval is XLEN/STEP+2 cycles.
- flush:
  - in RUN or DONE, the next state is IDLE and rsp_valid is 0 the next cycle;
  - any accumulated data is discarded;
  - flush has priority over req and rsp handshakes;
  - a request presented in the same cycle as flush is not accepted.
- g_resetn low has priority over flush and returns everything to reset values, including mid-RUN.
- Request inputs are sampled only on the accept cycle. Later changes to rs1, rs2 or the mode bits have no effect.
- Zero operands take the full latency; there is no early-out.

Test Plan:
- XLEN=32, STEP=1, mul 7*6 (all flags 0) -> result=0x0000002A; rsp_valid first high exactly 32 cycles after the accept edge.
- mulh signed/signed 0x80000000*0x80000000 -> 0x40000000. mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. mulhsu (lhs signed) 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- carryless: clmul 0x3,0x3 -> 0x00000005. clmulh 0x80000000,0x80000000 -> 0x40000000. carryless with lhs_sign=rhs_sign=1 gives identical values.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> result, rsp_valid=1 and req_ready=0 stable throughout. One cycle after the rsp handshake, req_ready=1.
- Abort: assert flush on the 10th RUN cycle -> IDLE next cycle, no rsp_valid. Then a new mul 0x10000*0x10000 with high=1 -> 0x00000001. Repeat the same sequence with g_resetn=0 instead of flush -> identical behaviour and all outputs at reset values.
- STEP=4, XLEN=32:
  - signed mul -1*-1 -> low 0x00000001, high 0x00000000, latency 8 cycles;
  - mulh 0x7FFFFFFF*0x80000000 -> 0xC0000000;
  - random compare against a reference model for all six ops at STEP in {1,2,8}.

Source files
------------

// File: rtl/xc_malu_mul_seq.sv
// xc_malu_mul_seq: iterative shift-add multiplier for mul/mulh*/clmul* retiring STEP multiplier bits per cycle
module xc_malu_mul_seq #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            lhs_sign,
  input  logic            rhs_sign,
  input  logic            carryless,
  input  logic            high,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] result
);
  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N) + 1;
  localparam int W  = XLEN + STEP;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0] a, b;
  logic [CW-1:0] cnt;
  logic ls, rs, cl, hi;
  logic last, sx, neg, accept;
  logic [W-1:0] ae, be, he, sum, clp, step_sum;
  logic [2*XLEN+STEP-1:0] wide;
  assign last = cnt == CW'(N - 1);
  assign sx = ls && !cl;
  // the multiplier's top chunk carries negative weight in the final step when rs2 is signed
  assign neg = rs && !cl && last;
  assign ae = {{STEP{sx && a[XLEN-1]}}, a};
  assign be = {{XLEN{neg && b[STEP-1]}}, b[STEP-1:0]};
  assign he = {{STEP{sx && acc[2*XLEN-1]}}, acc[2*XLEN-1:XLEN]};
  assign sum = he + ae * be;
  always_comb begin
    clp = {{STEP{1'b0}}, acc[2*XLEN-1:XLEN]};
    for (int i = 0; i < STEP; i++)
      if (b[i]) clp = clp ^ ({{STEP{1'b0}}, a} << i);
  end
  assign step_sum = cl ? clp : sum;
  assign wide = {step_sum, acc[XLEN-1:0]};
  assign accept = state == IDLE && req_valid && !flush;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign result = (state == DONE) ? (hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]) : '0;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (accept) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (state == DONE && rsp_ready) state_n = IDLE;
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= IDLE;
      acc <= '0;
      a <= '0;
      b <= '0;
      cnt <= '0;
      ls <= 1'b0;
      rs <= 1'b0;
      cl <= 1'b0;
      hi <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a <= rs1;
        b <= rs2;
        ls <= lhs_sign;
        rs <= rhs_sign;
        cl <= carryless;
        hi <= high;
        acc <= '0;
        cnt <= '0;
      end else if (state == RUN && !flush) begin
        acc <= wide[2*XLEN+STEP-1:STEP];
        b <= b >> STEP;
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// tb_xc_malu_mul_seq: four instances (STEP 1,2,4,8) checked against an arithmetic product model
module tb_xc_malu_mul_seq;
  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic [3:0] flush = '0, req_valid = '0, rsp_ready = '0;
  logic [3:0] req_ready, rsp_valid;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic lhs_sign = 1'b0, rhs_sign = 1'b0, carryless = 1'b0, high = 1'b0;
  logic [3:0][31:0] res;
  int n_chk = 0, n_pass = 0;

  always #5 g_clk = ~g_clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    xc_malu_mul_seq #(.XLEN(32), .STEP(1 << g)) u_dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .rs1(rs1), .rs2(rs2), .lhs_sign(lhs_sign), .rhs_sign(rhs_sign),
      .carryless(carryless), .high(high),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .result(res[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ls, input logic rs, input logic cl);
    logic [63:0] xe, ye, p;
    p = '0;
    xe = {{32{ls & x[31]}}, x};
    ye = {{32{rs & y[31]}}, y};
    if (cl) begin
      for (int i = 0; i < 32; i++) if (y[i]) p = p ^ ({32'b0, x} << i);
    end else p = xe * ye;
    return p;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] r, input logic [2:0] s);
    return s == 3'd0 ? 32'h0 : s == 3'd1 ? 32'hFFFF_FFFF : s == 3'd2 ? 32'h8000_0000 :
           s == 3'd3 ? 32'h7FFF_FFFF : s == 3'd4 ? 32'h1 : r;
  endfunction

  task automatic run_op(input int k, input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic ls, input logic rs, input logic cl, input logic hi,
                        input logic [31:0] e, input int hold);
    int lat;
    chk({tag, ":req_ready_idle"}, req_ready[k], 1);
    rs1 = x; rs2 = y; lhs_sign = ls; rhs_sign = rs; carryless = cl; high = hi;
    req_valid[k] = 1'b1;
    @(posedge g_clk); #1;
    // scramble request inputs: only the accept cycle may matter
    req_valid[k] = 1'b0;
    rs1 = $urandom; rs2 = $urandom;
    {lhs_sign, rhs_sign, carryless, high} = 4'($urandom);
    lat = 0;
    while (!rsp_valid[k] && lat < 300) begin
      @(posedge g_clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 64'(lat), 64'(32 >> k));
    chk({tag, ":result"}, res[k], e);
    chk({tag, ":req_ready_done"}, req_ready[k], 0);
    for (int c = 0; c < hold; c++) begin
      @(posedge g_clk); #1;
      chk({tag, ":hold_valid"}, rsp_valid[k], 1);
      chk({tag, ":hold_ready"}, req_ready[k], 0);
      chk({tag, ":hold_result"}, res[k], e);
    end
    rsp_ready[k] = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready[k] = 1'b0;
    chk({tag, ":req_ready_after"}, req_ready[k], 1);
    chk({tag, ":rsp_valid_after"}, rsp_valid[k], 0);
  endtask

  task automatic abort(input logic use_rst);
    logic seen;
    rs1 = 32'd7; rs2 = 32'd6; {lhs_sign, rhs_sign, carryless, high} = 4'b0;
    req_valid[0] = 1'b1;
    @(posedge g_clk); #1;
    req_valid[0] = 1'b0;
    repeat (9) @(posedge g_clk);
    #1;
    if (use_rst) g_resetn = 1'b0;
    else flush[0] = 1'b1;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    flush[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort:req_ready", req_ready[k], 1);
      chk("abort:rsp_valid", rsp_valid[k], 0);
      chk("abort:result", res[k], 0);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge g_clk); #1;
      if (rsp_valid[0]) seen = 1'b1;
    end
    chk("abort:no_rsp", seen, 0);
    run_op(0, "abort_next", 32'h10000, 32'h10000, 0, 0, 0, 1, 32'h1, 0);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] x, y;
    logic [3:0] m;
    int lat;
    repeat (2) @(posedge g_clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("reset:req_ready", req_ready[k], 1);
      chk("reset:rsp_valid", rsp_valid[k], 0);
      chk("reset:result", res[k], 0);
    end
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    run_op(0, "mul7x6", 32'd7, 32'd6, 0, 0, 0, 0, 32'h2A, 0);
    run_op(0, "mulh_ss", 32'h8000_0000, 32'h8000_0000, 1, 1, 0, 1, 32'h4000_0000, 0);
    run_op(0, "mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'hFFFF_FFFE, 0);
    run_op(0, "mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 1, 32'hFFFF_FFFF, 0);
    run_op(0, "clmul", 32'h3, 32'h3, 0, 0, 1, 0, 32'h5, 0);
    run_op(0, "clmulh", 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 1, 32'h4000_0000, 0);
    run_op(0, "clmul_sgn", 32'h3, 32'h3, 1, 1, 1, 0, 32'h5, 0);
    run_op(0, "clmulh_sgn", 32'h8000_0000, 32'h8000_0000, 1, 1, 1, 1, 32'h4000_0000, 0);
    run_op(0, "backpressure", 32'h1234, 32'h10, 0, 0, 0, 0, 32'h12340, 5);
    abort(1'b0);
    abort(1'b1);
    run_op(2, "s4_mul_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'h1, 0);
    run_op(2, "s4_mul_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 1, 32'h0, 0);
    run_op(2, "s4_mulh", 32'h7FFF_FFFF, 32'h8000_0000, 1, 1, 0, 1, 32'hC000_0000, 0);
    // a request coinciding with flush in IDLE must be dropped
    req_valid[1] = 1'b1; flush[1] = 1'b1;
    @(posedge g_clk); #1;
    req_valid[1] = 1'b0; flush[1] = 1'b0;
    chk("flush_req:req_ready", req_ready[1], 1);
    @(posedge g_clk); #1;
    chk("flush_req:still_idle", req_ready[1], 1);
    // flush while holding a response
    rs1 = 32'd5; rs2 = 32'd5; {lhs_sign, rhs_sign, carryless, high} = 4'b0;
    req_valid[3] = 1'b1;
    @(posedge g_clk); #1;
    req_valid[3] = 1'b0;
    lat = 0;
    while (!rsp_valid[3] && lat < 50) begin
      @(posedge g_clk); #1;
      lat++;
    end
    chk("flush_done:latency", 64'(lat), 64'd4);
    chk("flush_done:result", res[3], 32'd25);
    flush[3] = 1'b1;
    @(posedge g_clk); #1;
    flush[3] = 1'b0;
    chk("flush_done:rsp_valid", rsp_valid[3], 0);
    chk("flush_done:req_ready", req_ready[3], 1);
    chk("flush_done:result0", res[3], 0);
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 25; t++) begin
        x = pick($urandom, 3'($urandom_range(0, 7)));
        y = pick($urandom, 3'($urandom_range(0, 7)));
        m = 4'($urandom);
        p = model(x, y, m[0], m[1], m[2]);
        run_op(k, $sformatf("rnd_s%0d_%0d", 1 << k, t), x, y, m[0], m[1], m[2], m[3],
               m[3] ? p[63:32] : p[31:0], 0);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
